bloom_line_engine: RTL
======================

BLOOM_LINE_ENGINE -- requirements
Module: bloom_line_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MAIN_HASH_WIDTH, 30, line address width.
REQ-002 SUBSIDIARY_HASH_WIDTH, 9, bit index width within a line; line width LINE_WIDTH = 2**SUBSIDIARY_HASH_WIDTH (512).
REQ-003 NUM_SUBSIDIARY_HASH, 6, bit indices per element.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rstb  in  1  synchronous active-high reset
- hash_valid  in  1  hash presented by the upstream hash pipeline
- hash_op  in  1  0 = query, 1 = insert; qualified by hash_valid
- main_hash  in  MAIN_HASH_WIDTH  line address
- subsidiary_hash_values  in  NUM_SUBSIDIARY_HASH*SUBSIDIARY_HASH_WIDTH  bit indices; index i = bits [9i+8:9i]
- ready4_hash  out  1  engine accepts a hash
- mem_rd_req  out  1  line read request
- mem_rd_ready  in  1  memory accepts the read request
- mem_addr  out  MAIN_HASH_WIDTH  line address for read and write
- mem_rd_data_valid  in  1  read data returned
- mem_rd_data  in  LINE_WIDTH  line contents
- mem_wr_req  out  1  line write request
- mem_wr_ready  in  1  memory accepts the write
- mem_wr_data  out  LINE_WIDTH  updated line
- result_valid  out  1  result available
- result_hit  out  1  all indexed bits were set before this operation
- result_ready  in  1  consumer takes the result

Function
REQ-006 States SHALL be IDLE, RD_REQ, RD_WAIT, WR, RESULT.
REQ-007 ready4_hash SHALL be 1 only in IDLE; a hash SHALL be accepted on a cycle with hash_valid=1 and ready4_hash=1.
REQ-008 On acceptance, main_hash, indices, and hash_op SHALL be registered; the next state SHALL be RD_REQ.
REQ-009 RD_REQ: mem_rd_req=1 with mem_addr set to the registered main_hash; mem_rd_req and mem_addr SHALL hold until mem_rd_ready=1, then go to RD_WAIT.
REQ-010 RD_WAIT: mem_rd_data_valid asserted before RD_WAIT SHALL be ignored; on mem_rd_data_valid=1 the engine SHALL compute mask = OR of one-hot(index i) over all i, and hit = ((mem_rd_data & mask) == mask).
REQ-011 Duplicate indices SHALL be legal; they set or test the same bit once.
REQ-012 Query, or insert with hit=1: go straight to RESULT; no write is issued.
REQ-013 Insert with hit=0: register mem_wr_data = mem_rd_data | mask and go to WR.
REQ-014 WR: mem_wr_req=1 with mem_addr equal to the read address; mem_wr_req, mem_addr, and mem_wr_data SHALL hold until mem_wr_ready=1, then go to RESULT.
REQ-015 RESULT: result_valid=1 and result_hit=hit, both held stable until result_ready=1, then return to IDLE.
REQ-016 A new hash SHALL be accepted no earlier than the cycle after the result handshake.
REQ-017 Minimum latency, acceptance to result_valid, with zero-wait memory SHALL be 3 cycles for query and 4 cycles for an insert that writes.
REQ-018 mem_rd_req and mem_wr_req SHALL never be high in the same cycle.
REQ-019 All outputs SHALL be registered, except ready4_hash, which is decoded from state.

Reset
REQ-020 While rstb=1 the state SHALL go to IDLE; in the following cycle ready4_hash=1 and mem_rd_req, mem_wr_req, result_valid, and result_hit SHALL be 0; mem_addr and mem_wr_data SHALL be 0.
REQ-021 Reset in any state SHALL abort the operation; no write or result SHALL follow, and late mem_rd_data_valid SHALL be ignored.

Verification
REQ-022 Query, main_hash=0x0000_0005, indices {0,1,2,3,4,511}, memory returns all-ones -> mem_addr=5, no mem_wr_req, result_hit=1.
REQ-023 Insert, same hash, memory returns 0 -> mem_wr_data has only bits 0,1,2,3,4,511 set; result_hit=0; a following query returning that data -> result_hit=1.
REQ-024 Insert, indices all 7, line already has bit 7 set -> no write; result_hit=1.
REQ-025 mem_rd_ready low 3 cycles, mem_wr_ready low 2 cycles, result_ready low 4 cycles -> mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, and the result held stable; ready4_hash=0 throughout; exactly one read and one write.
REQ-026 rstb pulsed in RD_WAIT, then mem_rd_data_valid arrives -> no mem_wr_req, no result_valid; ready4_hash=1 the cycle after reset.
REQ-027 hash_valid held high across back-to-back operations -> each hash accepted only in IDLE; result count equals accepted count.

Source files
------------

// File: rtl/bloom_line_engine.sv
// Bloom-filter line engine: reads one memory line per hash, tests the indexed
// bits, and on a missing insert writes the line back with those bits set.
module bloom_line_engine #(
   parameter int unsigned MAIN_HASH_WIDTH       = 30,
   parameter int unsigned SUBSIDIARY_HASH_WIDTH = 9,
   parameter int unsigned NUM_SUBSIDIARY_HASH   = 6,
   localparam int unsigned LINE_WIDTH           = 2 ** SUBSIDIARY_HASH_WIDTH
) (
   input  logic                                               clk,
   input  logic                                               rstb,
   input  logic                                               hash_valid,
   input  logic                                               hash_op,
   input  logic [MAIN_HASH_WIDTH-1:0]                         main_hash,
   input  logic [NUM_SUBSIDIARY_HASH*SUBSIDIARY_HASH_WIDTH-1:0] subsidiary_hash_values,
   output logic                                               ready4_hash,
   output logic                                               mem_rd_req,
   input  logic                                               mem_rd_ready,
   output logic [MAIN_HASH_WIDTH-1:0]                         mem_addr,
   input  logic                                               mem_rd_data_valid,
   input  logic [LINE_WIDTH-1:0]                              mem_rd_data,
   output logic                                               mem_wr_req,
   input  logic                                               mem_wr_ready,
   output logic [LINE_WIDTH-1:0]                              mem_wr_data,
   output logic                                               result_valid,
   output logic                                               result_hit,
   input  logic                                               result_ready
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR,
      RESULT
   } state_e;

   state_e                                               state_q, state_d;
   logic                                                 op_q, op_d;
   logic [NUM_SUBSIDIARY_HASH*SUBSIDIARY_HASH_WIDTH-1:0] idx_q, idx_d;
   logic                                                 hit_q, hit_d;
   logic [MAIN_HASH_WIDTH-1:0]                           mem_addr_q, mem_addr_d;
   logic [LINE_WIDTH-1:0]                                mem_wr_data_q, mem_wr_data_d;
   logic                                                 mem_rd_req_q, mem_rd_req_d;
   logic                                                 mem_wr_req_q, mem_wr_req_d;
   logic                                                 result_valid_q, result_valid_d;
   logic                                                 result_hit_q, result_hit_d;
   logic [LINE_WIDTH-1:0]                                mask;
   logic                                                 rd_hit;

   // Duplicate indices simply land on the same mask bit.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < NUM_SUBSIDIARY_HASH; i++) begin
         mask[idx_q[i*SUBSIDIARY_HASH_WIDTH +: SUBSIDIARY_HASH_WIDTH]] = 1'b1;
      end
   end

   assign rd_hit = ((mem_rd_data & mask) == mask);

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      idx_d         = idx_q;
      hit_d         = hit_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      case (state_q)
         IDLE: begin
            if (hash_valid) begin
               state_d    = RD_REQ;
               op_d       = hash_op;
               idx_d      = subsidiary_hash_values;
               mem_addr_d = main_hash;
            end
         end
         RD_REQ: begin
            if (mem_rd_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rd_data_valid) begin
               hit_d = rd_hit;
               if (op_q && !rd_hit) begin
                  state_d       = WR;
                  mem_wr_data_d = mem_rd_data | mask;
               end else begin
                  state_d = RESULT;
               end
            end
         end
         WR: begin
            if (mem_wr_ready) state_d = RESULT;
         end
         RESULT: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Request/result flags are registered copies of the state being entered.
      mem_rd_req_d   = (state_d == RD_REQ);
      mem_wr_req_d   = (state_d == WR);
      result_valid_d = (state_d == RESULT);
      result_hit_d   = (state_d == RESULT) && hit_d;
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q        <= IDLE;
         op_q           <= 1'b0;
         idx_q          <= '0;
         hit_q          <= 1'b0;
         mem_addr_q     <= '0;
         mem_wr_data_q  <= '0;
         mem_rd_req_q   <= 1'b0;
         mem_wr_req_q   <= 1'b0;
         result_valid_q <= 1'b0;
         result_hit_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         idx_q          <= idx_d;
         hit_q          <= hit_d;
         mem_addr_q     <= mem_addr_d;
         mem_wr_data_q  <= mem_wr_data_d;
         mem_rd_req_q   <= mem_rd_req_d;
         mem_wr_req_q   <= mem_wr_req_d;
         result_valid_q <= result_valid_d;
         result_hit_q   <= result_hit_d;
      end
   end

   assign ready4_hash  = (state_q == IDLE);
   assign mem_rd_req   = mem_rd_req_q;
   assign mem_wr_req   = mem_wr_req_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wr_data  = mem_wr_data_q;
   assign result_valid = result_valid_q;
   assign result_hit   = result_hit_q;

endmodule
